// File: rtl/spi_serv_pkg.sv
// Shared frame geometry, control/status bit positions and FSM states for the
// serv debug-bridge SPI master.
package spi_serv_pkg;

  localparam int FRAME_W = 72;
  localparam int RESP_W  = 40;

  localparam int CTRL_CPU_RST = 0;
  localparam int CTRL_SYS_RST = 1;
  localparam int CTRL_START   = 2;
  localparam int CTRL_WE      = 3;

  localparam int STAT_BUSY = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/spi_master_serv_clkgen.sv
// SCK generator: half-period down-counter with registered SCK and single-cycle
// rise/fall strobes that mark the clk edge on which SCK changes.
module spi_master_serv_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_run,
  output logic o_sclk,
  output logic o_tick,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;

  // i_en counts half-periods; i_run additionally lets SCK toggle on each tick.
  always_comb begin
    o_tick = i_en && (cnt_q == '0);
    o_rise = o_tick && i_run && !sclk_q;
    o_fall = o_tick && i_run && sclk_q;
    cnt_d  = (!i_en || o_tick) ? CNT_LOAD : cnt_q - 1'b1;
    sclk_d = sclk_q;
    if (!i_en)       sclk_d = 1'b0;
    else if (o_rise) sclk_d = 1'b1;
    else if (o_fall) sclk_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= CNT_LOAD;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign o_sclk = sclk_q;

endmodule

// File: rtl/spi_master_serv.sv
// SPI mode-0 master sending one 72-bit serv debug-bridge frame per command and
// capturing the 40-bit response. Busy polling: define SPI_MASTER_SERV_POLL_EN.
//
// state    | meaning
// IDLE     | ready for a command
// SETUP    | CS asserted, first MOSI bit presented for one half-period
// SHIFT    | 72 SCK cycles, then one low half-period before CS release
// HOLD     | CS released for one half-period
// DONE     | response published, o_done pulse
module spi_master_serv
  import spi_serv_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int MAX_POLLS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_ctrl,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [2:0]  o_status,
  output logic        o_timeout,
  output logic        o_sclk,
  output logic        o_cs_n,
  output logic        o_mosi,
  input  logic        i_miso
);

  if (CLK_DIV < 1 || MAX_POLLS < 0) begin : g_bad_param
    $error("spi_master_serv: CLK_DIV must be >= 1 and MAX_POLLS >= 0");
  end

  state_e               state_q, state_d;
  logic                 ready_q, ready_d, done_q, done_d, cs_n_q, cs_n_d;
  logic                 mosi_q, mosi_d, tail_q, tail_d, timeout_q, timeout_d;
  logic [FRAME_W-1:0]   tx_q, tx_d;
  logic [RESP_W-1:0]    rx_q, rx_d;
  logic [6:0]           bit_cnt_q, bit_cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [2:0]           status_q, status_d;
  logic                 repoll, timeout_hit;
  logic                 clk_en, clk_run, tick, rise, fall;

`ifdef SPI_MASTER_SERV_POLL_EN
  localparam int PCNT_W = (MAX_POLLS > 1) ? $clog2(MAX_POLLS + 1) : 1;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 poll_q, poll_d;
  logic [PCNT_W-1:0]    poll_cnt_q, poll_cnt_d;
`endif

  assign clk_en  = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
  assign clk_run = (state_q == ST_SETUP) || ((state_q == ST_SHIFT) && !tail_q);

  spi_master_serv_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (clk_en),
    .i_run  (clk_run),
    .o_sclk (o_sclk),
    .o_tick (tick),
    .o_rise (rise),
    .o_fall (fall)
  );

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    done_d      = done_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    tail_d      = tail_q;
    timeout_d   = timeout_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    rdata_d     = rdata_q;
    status_d    = status_q;
    repoll      = 1'b0;
    timeout_hit = 1'b0;
`ifdef SPI_MASTER_SERV_POLL_EN
    frame_d     = frame_q;
    poll_d      = poll_q;
    poll_cnt_d  = poll_cnt_q;
    timeout_hit = poll_q && rx_q[STAT_BUSY];
    repoll      = timeout_hit && (poll_cnt_q != PCNT_W'(MAX_POLLS));
`endif

    // Only the first 40 rising edges carry response bits.
    if (rise && (bit_cnt_q < 7'(RESP_W))) rx_d = {rx_q[RESP_W-2:0], i_miso};
    if (fall) begin
      tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
      mosi_d = tx_q[FRAME_W-2];
      if (bit_cnt_q == 7'(FRAME_W - 1)) tail_d = 1'b1;
      else                              bit_cnt_d = bit_cnt_q + 7'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_valid && ready_q) begin
          tx_d      = {i_addr, i_wdata, 4'h0, i_ctrl};
          mosi_d    = i_addr[31];
          cs_n_d    = 1'b0;
          ready_d   = 1'b0;
          bit_cnt_d = '0;
          tail_d    = 1'b0;
          state_d   = ST_SETUP;
`ifdef SPI_MASTER_SERV_POLL_EN
          frame_d    = {i_addr, i_wdata, 4'h0, i_ctrl};
          poll_d     = i_ctrl[CTRL_START];
          poll_cnt_d = '0;
`endif
        end
      end
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (tick && tail_q) begin
          cs_n_d  = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tick && repoll) begin
`ifdef SPI_MASTER_SERV_POLL_EN
          tx_d             = frame_q;
          tx_d[CTRL_START] = 1'b0;
          mosi_d           = frame_q[FRAME_W-1];
          poll_cnt_d       = poll_cnt_q + 1'b1;
`endif
          cs_n_d    = 1'b0;
          bit_cnt_d = '0;
          tail_d    = 1'b0;
          state_d   = ST_SETUP;
        end else if (tick) begin
          done_d    = 1'b1;
          rdata_d   = rx_q[RESP_W-1:8];
          status_d  = rx_q[2:0];
          timeout_d = timeout_hit;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      tail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      rdata_q    <= '0;
      status_q   <= '0;
`ifdef SPI_MASTER_SERV_POLL_EN
      frame_q    <= '0;
      poll_q     <= 1'b0;
      poll_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      tail_q     <= tail_d;
      timeout_q  <= timeout_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      bit_cnt_q  <= bit_cnt_d;
      rdata_q    <= rdata_d;
      status_q   <= status_d;
`ifdef SPI_MASTER_SERV_POLL_EN
      frame_q    <= frame_d;
      poll_q     <= poll_d;
      poll_cnt_q <= poll_cnt_d;
`endif
    end
  end

  assign o_ready   = ready_q;
  assign o_done    = done_q;
  assign o_cs_n    = cs_n_q;
  assign o_mosi    = mosi_q;
  assign o_rdata   = rdata_q;
  assign o_status  = status_q;
  assign o_timeout = timeout_q;

endmodule

// File: doc/spi_master_serv.md
# spi_master_serv

- Host-side SPI master for the serv debug bridge.
- Accepts one bus command (address, write data, control bits) and serialises it as a 72-bit SPI frame towards the on-chip SPI slave bridge.
- Captures the 40-bit response (read data plus status) during the same frame.
- Sits in the test/bring-up harness or an FPGA host wrapper, driving the slave's shift register from the other end of the link.

## Interface
Parameters:
- CLK_DIV, 4: SCK half-period in clk cycles, ≥1.
- MAX_POLLS, 15: poll-frame limit, used only with SPI_MASTER_SERV_POLL_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  command request.
- o_ready  out  1  idle, able to accept a command.
- i_addr  in  32  bus address, frame bits [71:40].
- i_wdata  in  32  write data, frame bits [39:8].
- i_ctrl  in  4  frame bits [3:0]: bit0 cpu_reset, bit1 system_reset, bit2 start, bit3 we. Frame bits [7:4] are sent as 0.
- o_done  out  1  one-cycle pulse when the response is valid.
- o_rdata  out  32  response bits [39:8].
- o_status  out  3  response bits [2:0]: {busy, system_reset, cpu_reset}.
- o_timeout  out  1  poll limit hit; valid with o_done.
- o_sclk  out  1  SPI clock, CPOL=0.
- o_cs_n  out  1  chip select, active-low.
- o_mosi  out  1  serial data out, MSB first.
- i_miso  in  1  serial data in, MSB first.

## Operation
- Accept on clk edge with i_valid && o_ready. The 72-bit frame is latched; later input changes are ignored.
- States:
  - IDLE → SETUP on accept.
  - SETUP → SHIFT after CLK_DIV cycles.
  - SHIFT → HOLD after the 72nd falling SCK edge.
  - HOLD → DONE after CLK_DIV cycles.
  - DONE → IDLE the next cycle.
- Outputs by state:
  - o_cs_n = 0 in SETUP and SHIFT; 1 otherwise.
  - o_ready = 1 only in IDLE.
  - o_done = 1 only in DONE.
- SPI mode 0:
  - MOSI is valid before each rising edge.
  - On a rising edge, MISO is sampled into the receive register only for rising edges 1..40 (response bits 39..0). Rising edges 41..72 are ignored.
  - On a falling edge, MOSI advances to the next frame bit.
- Counters:
  - Half-period counter, 0..CLK_DIV-1.
  - Bit counter, 0..71. It saturates at 71; it does not wrap.
- In DONE, o_rdata, o_status and o_timeout update from the receive register. They hold until the next DONE.
- i_valid during a transfer: ignored and not queued.
- rst mid-frame: transfer is aborted with no o_done pulse. Outputs return to reset values on the next edge.
- Reset values:
  - o_cs_n = 1, o_ready = 1.
  - o_sclk, o_mosi, o_done, o_timeout = 0.
  - o_rdata = 0, o_status = 0.

## Timing
Accept at cycle 0, with D = CLK_DIV:
- o_cs_n falls and o_mosi = frame[71] at cycle 1.
- Rising edge k (k = 0..71) at cycle 1 + D·(2k+1).
- Falling edge k at cycle 1 + D·(2k+2).
- o_cs_n rises at cycle 1 + 145·D.
- o_done = 1 at cycle 1 + 146·D. o_ready returns the cycle after o_done.
- D = 1 is legal: SCK = clk/2.

## Configuration
SPI_MASTER_SERV_POLL_EN

- Defined:
  - After a frame with ctrl bit2 = 1, the master issues follow-up frames automatically, each with the same addr/wdata and ctrl bit2 forced to 0. Each follow-up starts one cycle after the previous HOLD.
  - Polling stops when the captured busy bit is 0. o_done is then pulsed with that frame's response.
  - After MAX_POLLS follow-up frames with busy still 1, o_done pulses with o_timeout = 1.
  - Intermediate frames do not pulse o_done.
- Undefined:
  - Exactly one frame per command.
  - o_timeout is tied to 0.
  - The MAX_POLLS parameter is unused.

## Structure
- Package spi_serv_pkg holds:
  - FRAME_W = 72, RESP_W = 40.
  - Ctrl bit indices CTRL_CPU_RST = 0, CTRL_SYS_RST = 1, CTRL_START = 2, CTRL_WE = 3.
  - Status bit index STAT_BUSY = 2.
  - State enumeration.
- Sub-module spi_master_serv_clkgen: half-period counter producing o_sclk plus single-cycle rise/fall strobes. Enabled by the FSM.

## Test plan
- Write: CLK_DIV = 4, addr 0x0000_1000, wdata 0xDEAD_BEEF, ctrl 0x8.
  - SPI slave model receives 0x0000_1000_DEAD_BEEF_08.
  - o_done at cycle 585.
- Read: slave model returns 0x1234_5678_05.
  - o_rdata = 0x1234_5678, o_status = 3'b101.
- CLK_DIV = 1:
  - SCK period is 2 clk cycles.
  - o_done at cycle 147.
  - MISO sampled on rising edges only.
- Busy i_valid and reset:
  - i_valid held high through a transfer → exactly one frame.
  - rst at cycle 200 → o_cs_n = 1, o_ready = 1 next cycle, no o_done.
- Polling (POLL_EN, MAX_POLLS = 3), ctrl 0x4:
  - Slave busy for 2 frames → 3 frames total, o_timeout = 0.
  - Slave always busy → 4 frames, o_timeout = 1.
